periph_bus_ctrl: RTL
====================

PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, as the data width.
REQ-002 SHALL have parameter N_SLV, default 4 (range 2..16), as the number of peripheral slaves.
REQ-003 SHALL have parameter SLV_AW, default 8, as the word-address width of each slave region.
REQ-004 SHALL have parameter TIMEOUT, default 15 (range 1..255), as the maximum number of ACCESS cycles before a timeout error.
REQ-005 SHALL derive SELW = max(1, clog2(N_SLV)).
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_i  input  1  master request strobe, sampled in IDLE only.
REQ-009 we_i  input  1  1 = store, 0 = load.
REQ-010 addr_i  input  DW  master byte address.
REQ-011 wdata_i  input  DW  store data.
REQ-012 mask_i  input  4  byte-lane mask.
REQ-013 rdy_o  output  1  one-cycle transaction-complete pulse.
REQ-014 err_o  output  1  error flag, valid only while rdy_o = 1.
REQ-015 rdata_o  output  DW  load data, valid only while rdy_o = 1 and err_o = 0.
REQ-016 cs_o  output  N_SLV  one-hot slave chip selects.
REQ-017 we_o / addr_o / wdata_o / mask_o  output  1 / SLV_AW / DW / 4  registered slave-side copies of the request.
REQ-018 slv_rdy_i  input  N_SLV  per-slave access-done signals.
REQ-019 slv_rdata_i  input  N_SLV*DW  packed slave read data; slave i occupies bits [i*DW +: DW].

Function
REQ-020 Address decode SHALL be: index = addr_i[SLV_AW+2 +: SELW]; word address = addr_i[SLV_AW+1:2].
REQ-021 A request SHALL be unmapped if any of the following holds:
- any addr_i bit above SLV_AW+2+SELW-1 is 1;
- index >= N_SLV;
- mask_i == 0.
REQ-022 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-023 IDLE, req_i = 1, mapped: SHALL latch we/addr/wdata/mask and the index, drive cs_o[index] = 1 from the next cycle, clear the cycle counter, and go to ACCESS.
REQ-024 IDLE, req_i = 1, unmapped: SHALL keep cs_o = 0, set the pending error, and go to RESP.
REQ-025 ACCESS: cs_o SHALL stay one-hot, and we_o/addr_o/wdata_o/mask_o SHALL stay stable.
REQ-026 ACCESS: the counter SHALL increment each cycle while slv_rdy_i[index] = 0.
REQ-027 ACCESS, slv_rdy_i[index] = 1: SHALL capture slv_rdata_i[index] into rdata_o, clear the error, drop cs_o, and go to RESP.
REQ-028 ACCESS, counter == TIMEOUT and no ready: SHALL drop cs_o, set the error, and go to RESP.
- Ready and timeout in the same cycle: ready SHALL win.
REQ-029 RESP: rdy_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-030 req_i SHALL be ignored in ACCESS and RESP; a new request is accepted no earlier than the cycle after RESP.
REQ-031 slv_rdy_i bits of non-selected slaves SHALL be ignored at all times.
REQ-032 Minimum latency SHALL be: req_i at cycle 0, cs_o at cycle 1, rdy_o at cycle 2 when the slave is ready at cycle 1.
REQ-033 Unmapped latency SHALL be: rdy_o with err_o = 1 at cycle 1.
REQ-034 Timeout latency SHALL be: rdy_o at cycle TIMEOUT+2.
REQ-035 Outside RESP, rdy_o and err_o SHALL be 0; rdata_o SHALL hold its last captured value.
REQ-036 On a store, rdata_o SHALL be unchanged.
REQ-037 All outputs SHALL be driven from registers; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-038 rst = 1 SHALL asynchronously force:
- state = IDLE;
- cs_o, rdy_o, err_o, we_o, mask_o = 0;
- addr_o, wdata_o, rdata_o, counter = 0.
REQ-039 rst during ACCESS or RESP SHALL abort the transaction with no rdy_o pulse; the first request after rst deasserts SHALL be treated as fresh.

Verification
REQ-040 The bench SHALL cover: load, addr_i = 0x0000_0404 (index 1, word 1), slave 1 ready at cycle 1 with data 0xDEADBEEF -> cs_o = 0010 at cycle 1; rdy_o = 1, err_o = 0, rdata_o = 0xDEADBEEF at cycle 2.
REQ-041 The bench SHALL cover: store, addr_i = 0x0000_0C08, mask_i = 0011, wdata_i = 0x1234 -> cs_o = 1000, addr_o = 2, mask_o = 0011, we_o = 1; rdy_o at cycle 2; rdata_o unchanged.
REQ-042 The bench SHALL cover: addr_i = 0x0000_1000 (bit above the decode range) -> cs_o never asserts; rdy_o = 1 and err_o = 1 at cycle 1.
REQ-043 The bench SHALL cover: slave 2 selected, slv_rdy_i = 0 throughout, TIMEOUT = 15 -> cs_o = 0100 for cycles 1..16; rdy_o = 1, err_o = 1 at cycle 17.
REQ-044 The bench SHALL cover: slv_rdy_i[0] = 1 while slave 3 is selected, with slave 3 ready at cycle 4 -> no early completion; rdy_o at cycle 5 with slave 3 data.
REQ-045 The bench SHALL cover: rst asserted at cycle 2 of an ACCESS, then a new request -> all outputs 0 immediately, no rdy_o pulse, and the new request completes normally.

Source files
------------

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes a master request onto one of N_SLV slaves,
// waits for that slave's ready (or a timeout) and returns a one-cycle response.
module periph_bus_ctrl #(
    parameter int DW      = 32,
    parameter int N_SLV   = 4,
    parameter int SLV_AW  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DW-1:0]         addr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [3:0]            mask_i,
    output logic                  rdy_o,
    output logic                  err_o,
    output logic [DW-1:0]         rdata_o,
    output logic [N_SLV-1:0]      cs_o,
    output logic                  we_o,
    output logic [SLV_AW-1:0]     addr_o,
    output logic [DW-1:0]         wdata_o,
    output logic [3:0]            mask_o,
    input  logic [N_SLV-1:0]      slv_rdy_i,
    input  logic [N_SLV*DW-1:0]   slv_rdata_i
);

    localparam int SELW   = (N_SLV > 2) ? $clog2(N_SLV) : 1;
    localparam int HI_LSB = SLV_AW + 2 + SELW;
    localparam logic [SELW:0] N_SLV_W   = (SELW + 1)'(N_SLV);
    localparam logic [7:0]    TIMEOUT_W = 8'(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state;
    logic [SELW-1:0]  sel_idx;
    logic [7:0]       count;

    logic [SELW-1:0]  req_idx;
    logic             unmapped;
    logic [N_SLV-1:0] one_hot;
    logic             sel_rdy;
    logic [DW-1:0]    sel_rdata;

    // Any address bit above the decoded range, an out-of-range slave index,
    // or an empty byte mask makes the request unmapped.
    assign req_idx   = addr_i[SLV_AW+2 +: SELW];
    assign unmapped  = ((addr_i >> HI_LSB) != '0) ||
                       ({1'b0, req_idx} >= N_SLV_W) ||
                       (mask_i == 4'b0000);
    assign one_hot   = N_SLV'(1) << req_idx;
    assign sel_rdy   = slv_rdy_i[sel_idx];
    assign sel_rdata = slv_rdata_i[sel_idx*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_idx <= '0;
            count   <= '0;
            cs_o    <= '0;
            rdy_o   <= 1'b0;
            err_o   <= 1'b0;
            we_o    <= 1'b0;
            mask_o  <= 4'b0000;
            addr_o  <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_o <= 1'b0;
                    err_o <= 1'b0;
                    if (req_i) begin
                        if (unmapped) begin
                            rdy_o <= 1'b1;
                            err_o <= 1'b1;
                            state <= RESP;
                        end else begin
                            we_o    <= we_i;
                            addr_o  <= addr_i[SLV_AW+1:2];
                            wdata_o <= wdata_i;
                            mask_o  <= mask_i;
                            sel_idx <= req_idx;
                            cs_o    <= one_hot;
                            count   <= '0;
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (sel_rdy) begin
                        if (!we_o) begin
                            rdata_o <= sel_rdata;
                        end
                        cs_o  <= '0;
                        rdy_o <= 1'b1;
                        err_o <= 1'b0;
                        state <= RESP;
                    end else if (count == TIMEOUT_W) begin
                        cs_o  <= '0;
                        rdy_o <= 1'b1;
                        err_o <= 1'b1;
                        state <= RESP;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                RESP: begin
                    rdy_o <= 1'b0;
                    err_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cs_o  <= '0;
                    rdy_o <= 1'b0;
                    err_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
